// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, holds fabric reset, and counts lock losses
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int CNT_W              = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       locked,
   input  logic       soft_reset_req,
   output logic       sys_reset,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] lock_lost_count
);
   typedef enum logic [1:0] {WAIT_LOCK = 2'd0, STABILIZE = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_sync;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             lost_d;
   assign locked_sync = sync_q[SYNC_STAGES-1];
   assign state       = state_q;
   assign ready       = ~sys_reset;
   // lock synchroniser: locked is asynchronous, only the last stage is used
   always_ff @(posedge clock)
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
   // state, interval counter, loss counter and registered fabric reset
   always_ff @(posedge clock)
      if (reset) begin
         state_q         <= WAIT_LOCK;
         cnt_q           <= '0;
         lock_lost_count <= '0;
         sys_reset       <= 1'b1;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         lock_lost_count <= lost_d;
         sys_reset       <= state_d != RUN;
      end
   // next state: any captured lock drop restarts qualification; losses in RUN are counted
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      lost_d  = lock_lost_count;
      case (state_q)
         WAIT_LOCK: state_d = locked_sync ? STABILIZE : WAIT_LOCK;
         STABILIZE:
            if (!locked_sync)            state_d = WAIT_LOCK;
            else if (cnt_q == STAB_LAST) state_d = HOLD;
            else                         cnt_d   = cnt_q + 1'b1;
         HOLD:
            if (!locked_sync)            state_d = WAIT_LOCK;
            else if (cnt_q == HOLD_LAST) state_d = RUN;
            else                         cnt_d   = cnt_q + 1'b1;
         RUN:
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               lost_d  = lock_lost_count + {7'd0, lock_lost_count != 8'hff};
            end else if (soft_reset_req) state_d = HOLD;
         default: state_d = WAIT_LOCK;
      endcase
   end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of release, glitch, loss, soft reset, saturation and reset
module tb_pll_reset_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       locked = 1'b0;
   logic       soft_reset_req = 1'b0;
   logic       sys_reset, ready;
   logic [1:0] state;
   logic [7:0] lock_lost_count;
   int         tests = 0;
   int         fails = 0;
   int         exp_cnt = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4), .CNT_W(16)
   ) dut (
      .clock(clock), .reset(reset), .locked(locked), .soft_reset_req(soft_reset_req),
      .sys_reset(sys_reset), .ready(ready), .state(state), .lock_lost_count(lock_lost_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // expected state at edge e after locked is first sampled high at edge 0
   function automatic logic [1:0] exp_state(input int e);
      return e < 2 ? 2'd0 : e < 10 ? 2'd1 : e < 14 ? 2'd2 : 2'd3;
   endfunction

   task automatic release_check(input string tag);
      locked = 1'b1;
      for (int e = 0; e < 16; e++) begin
         @(negedge clock);
         check({tag, "_state"}, state, exp_state(e));
         check({tag, "_sys_reset"}, sys_reset, e < 14);
         check({tag, "_ready"}, ready, e >= 14);
         check({tag, "_count"}, lock_lost_count, exp_cnt);
      end
   endtask

   task automatic lose_lock(input string tag);
      locked = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check({tag, "_still_run"}, state, 3);
      @(negedge clock);
      exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
      check({tag, "_state"}, state, 0);
      check({tag, "_sys_reset"}, sys_reset, 1);
      check({tag, "_count"}, lock_lost_count, exp_cnt);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check("rst_state", state, 0);
      check("rst_sys_reset", sys_reset, 1);
      check("rst_ready", ready, 0);
      check("rst_count", lock_lost_count, 0);
      reset = 1'b0;
      release_check("release");
      lose_lock("loss1");
      release_check("relock");
      soft_reset_req = 1'b1;
      for (int e = 0; e < 5; e++) begin
         @(negedge clock);
         soft_reset_req = 1'b0;
         check("soft_state", state, e < 4 ? 2 : 3);
         check("soft_sys_reset", sys_reset, e < 4);
      end
      locked = 1'b0;
      @(negedge clock);
      @(negedge clock);
      soft_reset_req = 1'b1;
      @(negedge clock);
      soft_reset_req = 1'b0;
      exp_cnt++;
      check("prio_state", state, 0);
      check("prio_sys_reset", sys_reset, 1);
      check("prio_count", lock_lost_count, exp_cnt);
      for (int i = 0; i < 260; i++) begin
         locked = 1'b1;
         repeat (16) @(negedge clock);
         lose_lock("sat");
      end
      check("sat_final", lock_lost_count, 255);
      locked = 1'b1;
      repeat (12) @(negedge clock);
      check("hold_before_reset", state, 2);
      reset = 1'b1;
      locked = 1'b0;
      @(negedge clock);
      check("hold_rst_state", state, 0);
      check("hold_rst_sys_reset", sys_reset, 1);
      check("hold_rst_ready", ready, 0);
      check("hold_rst_count", lock_lost_count, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_cnt = 0;
      locked = 1'b1;
      for (int e = 0; e < 5; e++) begin
         @(negedge clock);
         check("glitch_pre_state", state, exp_state(e));
      end
      locked = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("glitch_mid_state", state, 1);
      release_check("glitch");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
